// File: rtl/line_follower_pkg.sv
// Shared types for the line follower: FSM state codes, motor direction encoding, sensor classifier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package line_follower_pkg;

    // FSM state codes as presented on state_o; codes 5..7 are never produced
    typedef enum logic [2:0] {
        ST_STANDBY = 3'd0,
        ST_FORWARD = 3'd1,
        ST_RIGHT   = 3'd2,
        ST_LEFT    = 3'd3,
        ST_SEARCH  = 3'd4
    } state_t;

    // Requested / driven direction of one motor
    typedef enum logic [1:0] {
        DIR_OFF = 2'd0,
        DIR_FWD = 2'd1,
        DIR_REV = 2'd2
    } dir_t;

    // Line position as seen by the filtered sensors
    typedef enum logic [1:0] {
        CL_LOST    = 2'd0,
        CL_FORWARD = 2'd1,
        CL_LEFT    = 2'd2,
        CL_RIGHT   = 2'd3
    } line_class_t;

    // H-bridge pin pair {fwd, rev}; never 2'b11 by construction
    function automatic logic [1:0] dir_to_pins(input dir_t d);
        logic [1:0] pins;
        case (d)
            DIR_FWD: pins = 2'b10;
            DIR_REV: pins = 2'b01;
            default: pins = 2'b00;
        endcase
        return pins;
    endfunction

    // flr = {front, left, right}; junctions (011, 111) count as straight ahead
    function automatic line_class_t classify(input logic [2:0] flr);
        line_class_t c;
        if (flr[1] && !flr[0]) begin
            c = CL_LEFT;
        end else if (!flr[1] && flr[0]) begin
            c = CL_RIGHT;
        end else if (flr != 3'b000) begin
            c = CL_FORWARD;
        end else begin
            c = CL_LOST;
        end
        return c;
    endfunction

    // Tracking state that corresponds to a non-LOST class
    function automatic state_t class_to_state(input line_class_t c);
        state_t s;
        case (c)
            CL_LEFT:    s = ST_LEFT;
            CL_RIGHT:   s = ST_RIGHT;
            CL_FORWARD: s = ST_FORWARD;
            default:    s = ST_STANDBY;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One-bit sensor conditioner: 2-flop synchroniser followed by a stable-sample debouncer.
// Latency: 2 + DEB_CYCLES cycles from an input edge to a filtered change.
// Backpressure: none; samples every cycle, a single disagreeing sample restarts the count.
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous sensor pin into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive samples differing from the filtered level; flip on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            dout       <= 1'b0;
        end else if (sync_q2 == dout) begin
            stable_cnt <= '0;
        end else if (stable_cnt == LAST_CNT) begin
            stable_cnt <= '0;
            dout       <= sync_q2;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/line_follower_ctrl.sv
// Line-follower motor controller: debounced sensors -> drive FSM -> dead-timed, PWM-gated H-bridges.
// Latency: sensor edge to state_o 3+DEB_CYCLES cycles; state_o to motors 1 cycle (+DEAD_CYCLES on reversal).
// Backpressure: none; free-running. Build option LINE_FOLLOWER_SEARCH_EN adds the SEARCH spin state.
module line_follower_ctrl
    import line_follower_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int DEB_CYCLES   = 4,
    parameter int DEAD_CYCLES  = 2,
    parameter int LOST_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       sensors,
    input  logic [CNT_W-1:0] duty,
    output logic [1:0]       motor_a,
    output logic [1:0]       motor_b,
    output logic             pwm_o,
    output logic [2:0]       state_o
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    logic [2:0]       filt;
    line_class_t      cls;
    state_t           state_q;
    state_t           state_nxt;
    logic             last_right_q;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_shadow;
    logic             shadow_armed;
    dir_t             req      [2];
    dir_t             pend_q   [2];
    dir_t             drive_q  [2];
    logic [DW-1:0]    dead_q   [2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (sensors[gi]),
            .dout  (filt[gi])
        );
    end

    assign cls = classify(filt);

`ifdef LINE_FOLLOWER_SEARCH_EN
    localparam int TW = $clog2(LOST_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOST_TIMEOUT - 1);

    logic [TW-1:0] search_cnt;

    // Cycles spent in SEARCH; cleared on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            search_cnt <= '0;
        end else if (state_q == ST_SEARCH && state_nxt == ST_SEARCH) begin
            search_cnt <= search_cnt + TW'(1);
        end else begin
            search_cnt <= '0;
        end
    end
`else
    logic lost_timeout_unused;
    assign lost_timeout_unused = (LOST_TIMEOUT != 0);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STANDBY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: en low always wins; tracking states follow the class every cycle
    always_comb begin
        state_nxt = ST_STANDBY;
        if (en) begin
            case (state_q)
                ST_STANDBY: begin
                    state_nxt = class_to_state(cls);
                end
                ST_FORWARD, ST_LEFT, ST_RIGHT: begin
                    if (cls != CL_LOST) begin
                        state_nxt = class_to_state(cls);
                    end else begin
`ifdef LINE_FOLLOWER_SEARCH_EN
                        state_nxt = ST_SEARCH;
`else
                        state_nxt = ST_STANDBY;
`endif
                    end
                end
`ifdef LINE_FOLLOWER_SEARCH_EN
                ST_SEARCH: begin
                    if (cls != CL_LOST) begin
                        state_nxt = class_to_state(cls);
                    end else if (search_cnt == TIMEOUT_LAST) begin
                        state_nxt = ST_STANDBY;
                    end else begin
                        state_nxt = ST_SEARCH;
                    end
                end
`endif
                default: state_nxt = ST_STANDBY;
            endcase
        end
    end

    // Requested motor directions for the current state
    always_comb begin
        req[0] = DIR_OFF;
        req[1] = DIR_OFF;
        case (state_q)
            ST_FORWARD: begin
                req[0] = DIR_FWD;
                req[1] = DIR_FWD;
            end
            ST_LEFT: begin
                req[0] = DIR_REV;
                req[1] = DIR_FWD;
            end
            ST_RIGHT: begin
                req[0] = DIR_FWD;
                req[1] = DIR_REV;
            end
`ifdef LINE_FOLLOWER_SEARCH_EN
            ST_SEARCH: begin
                req[0] = last_right_q ? DIR_FWD : DIR_REV;
                req[1] = last_right_q ? DIR_REV : DIR_FWD;
            end
`endif
            default: begin
                req[0] = DIR_OFF;
                req[1] = DIR_OFF;
            end
        endcase
    end

    // Remember the last turn direction so SEARCH spins the way the line was lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_right_q <= 1'b0;
        end else if (state_nxt == ST_LEFT) begin
            last_right_q <= 1'b0;
        end else if (state_nxt == ST_RIGHT) begin
            last_right_q <= 1'b1;
        end
    end

    // Free-running PWM counter; duty is sampled only at wrap and on the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            shadow_armed <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + CNT_W'(1);
            shadow_armed <= 1'b1;
            if (!shadow_armed || pwm_cnt == {CNT_W{1'b1}}) begin
                duty_shadow <= duty;
            end
        end
    end

    assign pwm_o = (pwm_cnt < duty_shadow);

    // Per-motor dead-time: a fwd<->rev flip blanks the bridge; another flip restarts the blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pend_q[i]  <= DIR_OFF;
                drive_q[i] <= DIR_OFF;
                dead_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] == DIR_OFF) begin
                    pend_q[i]  <= DIR_OFF;
                    drive_q[i] <= DIR_OFF;
                    dead_q[i]  <= '0;
                end else if (pend_q[i] != DIR_OFF && req[i] != pend_q[i]) begin
                    pend_q[i]  <= req[i];
                    drive_q[i] <= DIR_OFF;
                    dead_q[i]  <= DEAD_LOAD;
                end else if (dead_q[i] != '0) begin
                    drive_q[i] <= DIR_OFF;
                    dead_q[i]  <= dead_q[i] - DW'(1);
                end else begin
                    pend_q[i]  <= req[i];
                    drive_q[i] <= req[i];
                end
            end
        end
    end

    assign motor_a = dir_to_pins(drive_q[0]) & {2{pwm_o}};
    assign motor_b = dir_to_pins(drive_q[1]) & {2{pwm_o}};
    assign state_o = state_q;

endmodule

// File: tb/tb_line_follower_ctrl.sv
// Randomised + directed bench for line_follower_ctrl with a cycle-level reference model and scoreboard.
// Latency: expectations are pushed at each rising edge and popped at the following falling edge.
// Backpressure: n/a.
module tb_line_follower_ctrl;

    localparam int CNT_W        = 8;
    localparam int DEB_CYCLES   = 4;
    localparam int DEAD_CYCLES  = 2;
    localparam int LOST_TIMEOUT = 200;
    localparam int PERIOD       = 1 << CNT_W;

    typedef struct {
        logic [2:0] st;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       pwm;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       sensors;
    logic [CNT_W-1:0] duty;
    logic [1:0]       motor_a;
    logic [1:0]       motor_b;
    logic             pwm_o;
    logic [2:0]       state_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic last_pwm;

    // Reference model state
    int         m_n;
    logic [2:0] m_hist[$];
    logic [2:0] m_filt;
    int         m_state;
    bit         m_last_right;
    int         m_target[2];
    int         m_rev_edge[2];
    int         m_out[2];
    int         m_shadow;
    int         m_search_start;

    line_follower_ctrl #(
        .CNT_W        (CNT_W),
        .DEB_CYCLES   (DEB_CYCLES),
        .DEAD_CYCLES  (DEAD_CYCLES),
        .LOST_TIMEOUT (LOST_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sensors (sensors),
        .duty    (duty),
        .motor_a (motor_a),
        .motor_b (motor_b),
        .pwm_o   (pwm_o),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] pins(input int d);
        return (d == 1) ? 2'b10 : (d == 2) ? 2'b01 : 2'b00;
    endfunction

    // -1 = lost, otherwise the state code the class maps to
    function automatic int class_state(input logic [2:0] f);
        if (f == 3'b000) return -1;
        if (f[1] && !f[0]) return 3;
        if (!f[1] && f[0]) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_hist.delete();
        for (int j = 0; j < DEB_CYCLES + 2; j++) m_hist.push_back(3'b000);
        m_filt = 3'b000;
        m_state = 0;
        m_last_right = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_target[i]   = 0;
            m_rev_edge[i] = -1000000;
            m_out[i]      = 0;
        end
        m_shadow = 0;
        m_search_start = 0;
    endtask

    // Values of all registers after one more rising edge with the given inputs
    task automatic model_step(input logic [2:0] s, input logic e, input int d);
        int   cnt;
        int   req[2];
        int   c;
        int   ns;
        bit   all_new;
        exp_t x;
        m_n++;
        cnt = m_n % PERIOD;
        if (m_n == 1 || cnt == 0) m_shadow = d;

        // Drive request from the state held before this edge
        case (m_state)
            1: begin req[0] = 1; req[1] = 1; end
            2: begin req[0] = 1; req[1] = 2; end
            3: begin req[0] = 2; req[1] = 1; end
            4: begin req[0] = m_last_right ? 1 : 2; req[1] = m_last_right ? 2 : 1; end
            default: begin req[0] = 0; req[1] = 0; end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (req[i] == 0) begin
                m_target[i] = 0; m_rev_edge[i] = -1000000; m_out[i] = 0;
            end else if (m_target[i] != 0 && req[i] != m_target[i]) begin
                m_target[i] = req[i]; m_rev_edge[i] = m_n; m_out[i] = 0;
            end else begin
                m_target[i] = req[i];
                m_out[i] = (m_n - m_rev_edge[i] >= DEAD_CYCLES) ? req[i] : 0;
            end
        end

        // Next state from the filtered sensors held before this edge
        c = class_state(m_filt);
        if (!e) ns = 0;
        else if (m_state == 0) ns = (c < 0) ? 0 : c;
        else if (m_state >= 1 && m_state <= 3) begin
`ifdef LINE_FOLLOWER_SEARCH_EN
            ns = (c < 0) ? 4 : c;
`else
            ns = (c < 0) ? 0 : c;
`endif
        end else if (m_state == 4) begin
            ns = (c >= 0) ? c : ((m_n - m_search_start >= LOST_TIMEOUT) ? 0 : 4);
        end else ns = 0;
        if (ns == 4 && m_state != 4) m_search_start = m_n;
        if (ns == 3) m_last_right = 1'b0;
        if (ns == 2) m_last_right = 1'b1;
        m_state = ns;

        // Filter: synced sample lags the pin by 2 edges; flip after DEB_CYCLES disagreeing samples
        m_hist.push_front(s);
        void'(m_hist.pop_back());
        for (int b = 0; b < 3; b++) begin
            all_new = 1'b1;
            for (int j = 2; j < DEB_CYCLES + 2; j++) if (m_hist[j][b] == m_filt[b]) all_new = 1'b0;
            if (all_new) m_filt[b] = ~m_filt[b];
        end

        x.st  = 3'(m_state);
        x.pwm = (cnt < m_shadow);
        x.ma  = pins(m_out[0]) & {2{x.pwm}};
        x.mb  = pins(m_out[1]) & {2{x.pwm}};
        exp_q.push_back(x);
    endtask

    task automatic step(input logic [2:0] s, input logic e, input int d);
        sensors = s;
        en      = e;
        duty    = CNT_W'(d);
        @(posedge clk);
        model_step(s, e, d);
        #2;
        last_pwm = pwm_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_state", state_o, 0);
        check("reset_motor_a", motor_a, 0);
        check("reset_motor_b", motor_b, 0);
        check("reset_pwm", pwm_o, 0);
        repeat (3) @(posedge clk);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count PWM-high cycles over one full counter period starting at the wrap
    task automatic pwm_window(input int d0, input int d1, input int change_at, input string name, input int req);
        int hi;
        while (m_n % PERIOD != PERIOD - 1) step(3'b100, 1'b1, d0);
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step(3'b100, 1'b1, ((m_n + 1) % PERIOD >= change_at) ? d1 : d0);
            if (last_pwm) hi++;
        end
        check(name, hi, req);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_state", state_o, e.st);
            check("sb_motor_a", motor_a, e.ma);
            check("sb_motor_b", motor_b, e.mb);
            check("sb_pwm", pwm_o, e.pwm);
        end
    end

    initial begin
        int hold;
        logic [2:0] rs;
        int rd;
        rst_n = 1'b1; en = 1'b0; sensors = 3'b000; duty = '0;
        model_reset();
        #3;
        do_reset();

        // First line acquisition: 2 sync + 4 debounce + 1 state cycles
        repeat (DEB_CYCLES + 2) step(3'b100, 1'b1, 128);
        check("fwd_latency_before", state_o, 0);
        step(3'b100, 1'b1, 128);
        check("fwd_latency_at", state_o, 1);
        repeat (300) step(3'b100, 1'b1, 128);

        // Turn left (motor A reverses with dead-time), then back
        repeat (20) step(3'b010, 1'b1, 128);
        check("left_state", state_o, 3);
        repeat (20) step(3'b100, 1'b1, 128);

        // Short glitch must not disturb FORWARD
        repeat (3) step(3'b000, 1'b1, 128);
        repeat (10) begin
            step(3'b100, 1'b1, 128);
            check("glitch_state", state_o, 1);
        end

        // Duty shadowing and extremes
        pwm_window(64, 200, 100, "pwm_hi_64_then_change", 64);
        pwm_window(200, 200, PERIOD, "pwm_hi_200", 200);
        pwm_window(0, 0, PERIOD, "pwm_hi_0", 0);
        pwm_window(PERIOD - 1, PERIOD - 1, PERIOD, "pwm_hi_max", PERIOD - 1);

        // Enable drop
        step(3'b100, 1'b0, PERIOD - 1);
        check("en_low_state", state_o, 0);
        step(3'b100, 1'b0, PERIOD - 1);
        check("en_low_motors", {motor_a, motor_b}, 0);
        repeat (10) step(3'b100, 1'b1, 128);

        // Line lost from LEFT
        repeat (20) step(3'b010, 1'b1, 160);
        repeat (10) step(3'b000, 1'b1, 160);
`ifdef LINE_FOLLOWER_SEARCH_EN
        check("lost_search", state_o, 4);
        repeat (LOST_TIMEOUT) step(3'b000, 1'b1, 160);
        check("search_timeout", state_o, 0);
`else
        check("lost_standby", state_o, 0);
`endif

        // Randomised traffic
        for (int blk = 0; blk < 200; blk++) begin
            rs   = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) rd = $urandom_range(0, PERIOD - 1);
            else rd = int'(duty);
            for (int k = 0; k < hold; k++) step(rs, ($urandom_range(0, 19) != 0), rd);
        end

        // Reset in the middle of driving
        repeat (20) step(3'b001, 1'b1, 200);
        do_reset();
        repeat (DEB_CYCLES + 2) step(3'b001, 1'b1, 200);
        check("post_reset_no_drive", {motor_a, motor_b}, 0);
        repeat (20) step(3'b001, 1'b1, 200);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
